// File: rtl/ilc_pkg.sv
// ILC sequencer shared types, request opcodes and parameter helpers.
package ilc_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_QUIESCE,
    ST_ACT,
    ST_HALT,
    ST_STEP
  } state_e;

  typedef enum logic [1:0] {
    OP_DUMP   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_RESUME = 2'd2,
    OP_STEP   = 2'd3
  } op_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Phase timer width: must hold the larger of the two phase reload values.
  function automatic int unsigned timer_w(input int unsigned q, input int unsigned h);
    return $clog2(max_u(q, h) + 1);
  endfunction

  function automatic bit params_ok(input int unsigned cnt_w, input int unsigned q,
                                   input int unsigned h, input int unsigned auto_dump);
    return (cnt_w >= 1) && (q >= 1) && (h >= 1) && (auto_dump <= 1);
  endfunction

endpackage

// File: rtl/ilc_phase_timer.sv
// Loadable down-counter shared by the QUIESCE and ACT phases.
module ilc_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ilc_sequencer.sv
// Interrupt/load/checkpoint sequencer: gates the user clock enable, times the
// quiesce and strobe phases, counts enabled cycles and handles breakpoints.
module ilc_sequencer
  import ilc_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned QUIESCE_CYC  = 2,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned BP_AUTO_DUMP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] ld_cnt,
  input  logic             bp_en,
  input  logic [CNT_W-1:0] breakpoint,
  output logic             req_ack,
  output logic             clk_en,
  output logic             save,
  output logic             restore,
  output logic             busy,
  output logic             halted,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  if (!params_ok(CNT_W, QUIESCE_CYC, HOLD_CYC, BP_AUTO_DUMP)) begin : g_param_err
    $error("ilc_sequencer: CNT_W, QUIESCE_CYC, HOLD_CYC must be >= 1 and BP_AUTO_DUMP 0 or 1");
  end

  localparam int unsigned TW = timer_w(QUIESCE_CYC, HOLD_CYC);
  // Timer expires on its reload value's last cycle, so phases load N-1.
  localparam logic [TW-1:0] Q_LOAD = TW'(QUIESCE_CYC - 1);
  localparam logic [TW-1:0] H_LOAD = TW'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  op_e              req_op_e;
  logic             ret_halt_q, ret_halt_d;
  logic             ack_q, ack_d;
  logic             clk_en_q, clk_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expire;

  assign req_op_e = op_e'(req_op);
  assign cnt_inc  = cnt_q + 1'b1;

  ilc_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state, request acceptance, phase timer control and cycle counter.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ret_halt_d = ret_halt_q;
    ack_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = Q_LOAD;
    cnt_d      = clk_en_q ? cnt_inc : cnt_q;

    case (state_q)
      ST_RUN: begin
        // Breakpoint takes priority; a coincident request waits for HALT.
        if (bp_en && (cnt_inc == breakpoint)) begin
          if (BP_AUTO_DUMP != 0) begin
            state_d    = ST_QUIESCE;
            op_d       = OP_DUMP;
            ret_halt_d = 1'b1;
            tmr_load   = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end else if (req_valid) begin
          ack_d = 1'b1;
          if ((req_op_e == OP_DUMP) || (req_op_e == OP_LOAD)) begin
            state_d    = ST_QUIESCE;
            op_d       = req_op_e;
            ret_halt_d = 1'b0;
            tmr_load   = 1'b1;
          end
        end
      end
      ST_QUIESCE: begin
        if (tmr_expire) begin
          state_d  = ST_ACT;
          tmr_load = 1'b1;
          tmr_val  = H_LOAD;
        end
      end
      ST_ACT: begin
        if (tmr_expire) begin
          if (op_q == OP_LOAD) begin
            cnt_d = ld_cnt;
          end
          state_d = ret_halt_q ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        if (req_valid) begin
          ack_d = 1'b1;
          case (req_op_e)
            OP_DUMP, OP_LOAD: begin
              state_d    = ST_QUIESCE;
              op_d       = req_op_e;
              ret_halt_d = 1'b1;
              tmr_load   = 1'b1;
            end
            OP_RESUME: state_d = ST_RUN;
            OP_STEP:   state_d = ST_STEP;
          endcase
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    clk_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  // State, handshake, clock enable and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      op_q       <= OP_DUMP;
      ret_halt_q <= 1'b0;
      ack_q      <= 1'b0;
      clk_en_q   <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ret_halt_q <= ret_halt_d;
      ack_q      <= ack_d;
      clk_en_q   <= clk_en_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ack   = ack_q;
  assign clk_en    = clk_en_q;
  assign save      = (state_q == ST_ACT) && (op_q == OP_DUMP);
  assign restore   = (state_q == ST_ACT) && (op_q == OP_LOAD);
  assign busy      = (state_q == ST_QUIESCE) || (state_q == ST_ACT);
  assign halted    = (state_q == ST_HALT);
  assign done      = (state_q == ST_ACT) && tmr_expire;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_ilc_sequencer.sv
// Directed bench for ilc_sequencer with default parameters.
module tb_ilc_sequencer;
  import ilc_pkg::*;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] ld_cnt;
  logic        bp_en;
  logic [31:0] breakpoint;
  logic        req_ack;
  logic        clk_en;
  logic        save;
  logic        restore;
  logic        busy;
  logic        halted;
  logic        done;
  logic [31:0] cycle_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        vld;
    logic [1:0]  op;
    logic [31:0] ld;
    logic        ack;
    logic        cen;
    logic        sv;
    logic        rs;
    logic        bsy;
    logic        hlt;
    logic        dn;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  ilc_sequencer #(
    .CNT_W        (32),
    .QUIESCE_CYC  (2),
    .HOLD_CYC     (2),
    .BP_AUTO_DUMP (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .ld_cnt     (ld_cnt),
    .bp_en      (bp_en),
    .breakpoint (breakpoint),
    .req_ack    (req_ack),
    .clk_en     (clk_en),
    .save       (save),
    .restore    (restore),
    .busy       (busy),
    .halted     (halted),
    .done       (done),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic vld, input logic [1:0] op, input logic [31:0] ld,
                              input logic ack, input logic cen, input logic sv, input logic rs,
                              input logic bsy, input logic hlt, input logic dn,
                              input logic [31:0] cnt);
    vec_t v;
    v.vld = vld; v.op = op; v.ld = ld;
    v.ack = ack; v.cen = cen; v.sv = sv; v.rs = rs;
    v.bsy = bsy; v.hlt = hlt; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // A strobe must never overlap an enabled user clock.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      total_cnt++;
      if ((save || restore) && clk_en)
        $display("FAIL strobe_vs_clk_en: save=%b restore=%b clk_en=%b, required no overlap",
                 save, restore, clk_en);
      else
        pass_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int saves;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = OP_DUMP;
    ld_cnt     = '0;
    bp_en      = 1'b0;
    breakpoint = '0;

    repeat (2) @(posedge clk);
    #1;
    chk32("rst.cnt", cycle_cnt, 32'd0);
    chk1("rst.clk_en", clk_en, HI);
    chk1("rst.save", save, LO);
    chk1("rst.restore", restore, LO);
    chk1("rst.ack", req_ack, LO);
    chk1("rst.busy", busy, LO);
    chk1("rst.halted", halted, LO);
    chk1("rst.done", done, LO);
    reset_n = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    chk32("run5.cnt", cycle_cnt, 32'd5);
    chk1("run5.clk_en", clk_en, HI);
    chk1("run5.save", save, LO);
    chk1("run5.restore", restore, LO);

    //            vld op         ld            ack cen sv  rs  bsy hlt dn  cnt
    // DUMP from RUN: ack cycle 1, strobe cycles 3-4, done cycle 4, run at 5.
    tbl.push_back(mk(HI, OP_DUMP,   32'h0,        HI, LO, LO, LO, HI, LO, LO, 32'd6));
    tbl.push_back(mk(LO, OP_DUMP,   32'h0,        LO, LO, LO, LO, HI, LO, LO, 32'd6));
    tbl.push_back(mk(LO, OP_DUMP,   32'h0,        LO, LO, HI, LO, HI, LO, LO, 32'd6));
    tbl.push_back(mk(LO, OP_DUMP,   32'h0,        LO, LO, HI, LO, HI, LO, HI, 32'd6));
    tbl.push_back(mk(LO, OP_DUMP,   32'h0,        LO, HI, LO, LO, LO, LO, LO, 32'd6));
    tbl.push_back(mk(LO, OP_DUMP,   32'h0,        LO, HI, LO, LO, LO, LO, LO, 32'd7));
    // LOAD 0x100.
    tbl.push_back(mk(HI, OP_LOAD,   32'h100,      HI, LO, LO, LO, HI, LO, LO, 32'd8));
    tbl.push_back(mk(LO, OP_LOAD,   32'h100,      LO, LO, LO, LO, HI, LO, LO, 32'd8));
    tbl.push_back(mk(LO, OP_LOAD,   32'h100,      LO, LO, LO, HI, HI, LO, LO, 32'd8));
    tbl.push_back(mk(LO, OP_LOAD,   32'h100,      LO, LO, LO, HI, HI, LO, HI, 32'd8));
    tbl.push_back(mk(LO, OP_LOAD,   32'h100,      LO, HI, LO, LO, LO, LO, LO, 32'h100));
    tbl.push_back(mk(LO, OP_LOAD,   32'h100,      LO, HI, LO, LO, LO, LO, LO, 32'h101));
    // RESUME and STEP in RUN are acked and ignored.
    tbl.push_back(mk(HI, OP_RESUME, 32'h0,        HI, HI, LO, LO, LO, LO, LO, 32'h102));
    tbl.push_back(mk(LO, OP_RESUME, 32'h0,        LO, HI, LO, LO, LO, LO, LO, 32'h103));
    tbl.push_back(mk(HI, OP_STEP,   32'h0,        HI, HI, LO, LO, LO, LO, LO, 32'h104));
    tbl.push_back(mk(LO, OP_STEP,   32'h0,        LO, HI, LO, LO, LO, LO, LO, 32'h105));
    // LOAD all-ones, then counter wraps to zero.
    tbl.push_back(mk(HI, OP_LOAD,   32'hFFFFFFFF, HI, LO, LO, LO, HI, LO, LO, 32'h106));
    tbl.push_back(mk(LO, OP_LOAD,   32'hFFFFFFFF, LO, LO, LO, LO, HI, LO, LO, 32'h106));
    tbl.push_back(mk(LO, OP_LOAD,   32'hFFFFFFFF, LO, LO, LO, HI, HI, LO, LO, 32'h106));
    tbl.push_back(mk(LO, OP_LOAD,   32'hFFFFFFFF, LO, LO, LO, HI, HI, LO, HI, 32'h106));
    tbl.push_back(mk(LO, OP_LOAD,   32'hFFFFFFFF, LO, HI, LO, LO, LO, LO, LO, 32'hFFFFFFFF));
    tbl.push_back(mk(LO, OP_LOAD,   32'hFFFFFFFF, LO, HI, LO, LO, LO, LO, LO, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].vld;
      req_op    = tbl[i].op;
      ld_cnt    = tbl[i].ld;
      @(posedge clk); #1;
      chk1($sformatf("vec%0d.ack", i), req_ack, tbl[i].ack);
      chk1($sformatf("vec%0d.clk_en", i), clk_en, tbl[i].cen);
      chk1($sformatf("vec%0d.save", i), save, tbl[i].sv);
      chk1($sformatf("vec%0d.restore", i), restore, tbl[i].rs);
      chk1($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
      chk1($sformatf("vec%0d.halted", i), halted, tbl[i].hlt);
      chk1($sformatf("vec%0d.done", i), done, tbl[i].dn);
      chk32($sformatf("vec%0d.cnt", i), cycle_cnt, tbl[i].cnt);
    end

    // Reset asserted during ACT aborts the dump.
    req_valid = 1'b1;
    req_op    = OP_DUMP;
    @(posedge clk); #1;
    chk1("rstact.ack", req_ack, HI);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rstact.save_before", save, HI);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk1("rstact.save", save, LO);
    chk1("rstact.clk_en", clk_en, HI);
    chk32("rstact.cnt", cycle_cnt, 32'd0);
    chk1("rstact.busy", busy, LO);
    chk1("rstact.halted", halted, LO);
    reset_n = 1'b1;

    // Breakpoint at 10 with auto-dump, then STEP and RESUME from HALT.
    bp_en      = 1'b1;
    breakpoint = 32'd10;
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    chk32("bp.cnt9", cycle_cnt, 32'd9);
    chk1("bp.clk_en9", clk_en, HI);
    @(posedge clk); #1;
    chk32("bp.cnt_hit", cycle_cnt, 32'd10);
    chk1("bp.clk_en_hit", clk_en, LO);
    chk1("bp.busy_hit", busy, HI);
    saves = 0;
    for (int k = 0; k < 10 && !halted; k++) begin
      @(posedge clk); #1;
      if (save) saves++;
    end
    chk32("bp.save_cycles", saves, 32'd2);
    chk1("bp.halted", halted, HI);
    chk1("bp.clk_en_halt", clk_en, LO);
    chk32("bp.cnt_halt", cycle_cnt, 32'd10);

    req_valid = 1'b1;
    req_op    = OP_STEP;
    @(posedge clk); #1;
    chk1("step.ack", req_ack, HI);
    chk1("step.clk_en", clk_en, HI);
    chk1("step.halted", halted, LO);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk32("step.cnt", cycle_cnt, 32'd11);
    chk1("step.clk_en_after", clk_en, LO);
    chk1("step.halted_after", halted, HI);
    @(posedge clk); #1;
    chk32("step.cnt_hold", cycle_cnt, 32'd11);

    req_valid = 1'b1;
    req_op    = OP_RESUME;
    @(posedge clk); #1;
    chk1("resume.ack", req_ack, HI);
    chk1("resume.clk_en", clk_en, HI);
    chk1("resume.halted", halted, LO);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk32("resume.cnt", cycle_cnt, 32'd12);

    // DUMP request coincident with a breakpoint hit waits until HALT.
    breakpoint = 32'd5;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = OP_DUMP;
    @(posedge clk); #1;
    chk1("coin.ack_hit", req_ack, LO);
    chk1("coin.clk_en_hit", clk_en, LO);
    chk32("coin.cnt_hit", cycle_cnt, 32'd5);
    waited = 0;
    while (!req_ack && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk32("coin.ack_delay", waited, 32'd5);
    chk1("coin.ack", req_ack, HI);
    chk1("coin.busy_at_ack", busy, HI);
    req_valid = 1'b0;
    saves = 0;
    for (int k = 0; k < 10 && !halted; k++) begin
      @(posedge clk); #1;
      if (save) saves++;
    end
    chk32("coin.save_cycles", saves, 32'd2);
    chk1("coin.halted", halted, HI);
    chk32("coin.cnt", cycle_cnt, 32'd5);

    bp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
